// File: rtl/data_mem_responder.sv
// data_mem_responder: responder side of the core's data-memory port.
// Word-organised RAM split into four byte lanes. Stores commit in one cycle
// from IDLE. Loads return after READ_LATENCY cycles as a one-cycle read_valid
// pulse. Range, alignment and width faults are reported on access_fault.
module data_mem_responder #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read_enable,
    output logic        read_valid,
    output logic [31:0] read_data,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    input  logic [1:0]  write_wstrb,
    output logic        access_fault
);

    localparam int          AW     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  LAT_M1 = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic [1:0]  shift_reg;
    logic        load_fault_reg;
    logic        read_valid_reg;
    logic        access_fault_reg;

    logic [31:0]   st_offset;
    logic          st_misaligned;
    logic          st_fault;
    logic          st_fire;
    logic [AW-1:0] st_idx;
    logic [3:0]    lane_we;
    logic [31:0]   rd_addr;
    logic [31:0]   rd_offset;
    logic          rd_fault;
    logic          rd_fire;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    // Decode the store request and the load that completes on this edge.
    always_comb begin
        st_offset     = address - BASE_ADDR;
        st_misaligned = 1'b0;
        lane_we       = 4'b0000;
        case (write_wstrb)
            2'b00: begin
                st_misaligned          = 1'b0;
                lane_we[address[1:0]]  = 1'b1;
            end
            2'b01: begin
                st_misaligned = address[0];
                lane_we       = address[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                st_misaligned = (address[1:0] != 2'b00);
                lane_we       = 4'b1111;
            end
            default: begin
                st_misaligned = 1'b1;
                lane_we       = 4'b0000;
            end
        endcase
        st_fault = !({1'b0, st_offset} < SPAN) || st_misaligned;
        st_fire  = (state_reg == IDLE) && write_enable;
        st_idx   = st_offset[AW+1:2];

        // In IDLE the load address comes straight from the port (latency 1);
        // otherwise the latched address is used so input changes are ignored.
        rd_addr   = (state_reg == IDLE) ? address : addr_reg;
        rd_offset = rd_addr - BASE_ADDR;
        rd_fault  = !({1'b0, rd_offset} < SPAN);
        rd_idx    = rd_offset[AW+1:2];
        rd_fire   = ((state_reg == IDLE) && !write_enable && read_enable && (READ_LATENCY == 1))
                 || ((state_reg == WAIT) && (cnt_reg == 4'd1));
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] q_reg;
            logic [7:0] lane_wd;

            // Half stores replicate the low halfword, byte stores the low byte.
            assign lane_wd = (write_wstrb == 2'b10) ? write_data[8*gi +: 8]
                           : (write_wstrb == 2'b01) ? write_data[8*(gi%2) +: 8]
                           : write_data[7:0];

            // Lane write port; a reset cycle or a faulting store writes nothing.
            always_ff @(posedge clock) begin
                if (reset && st_fire && !st_fault && lane_we[gi])
                    mem[st_idx] <= lane_wd;
            end

            // Registered lane read, captured only when a load completes so the
            // returned word is held between loads.
            always_ff @(posedge clock) begin
                if (!reset)
                    q_reg <= 8'h00;
                else if (rd_fire)
                    q_reg <= mem[rd_idx];
            end

            assign rd_word[8*gi +: 8] = q_reg;
        end
    endgenerate

    // Load/store sequencing with registered pulse outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= 4'd0;
            addr_reg         <= 32'h0;
            shift_reg        <= 2'b00;
            load_fault_reg   <= 1'b0;
            read_valid_reg   <= 1'b0;
            access_fault_reg <= 1'b0;
        end else begin
            read_valid_reg   <= 1'b0;
            access_fault_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (write_enable) begin
                        access_fault_reg <= st_fault;
                    end else if (read_enable) begin
                        addr_reg  <= address;
                        cnt_reg   <= LAT_M1;
                        state_reg <= (READ_LATENCY == 1) ? VALID : WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1)
                        state_reg <= VALID;
                end
                VALID: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
            if (rd_fire) begin
                read_valid_reg   <= 1'b1;
                access_fault_reg <= rd_fault;
                load_fault_reg   <= rd_fault;
                shift_reg        <= rd_addr[1:0];
            end
        end
    end

    assign read_valid   = read_valid_reg;
    assign access_fault = access_fault_reg;
    assign read_data    = load_fault_reg ? 32'h0 : (rd_word >> {shift_reg, 3'b000});

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with latency 1 and
// default geometry, one with latency 3, a 64-word RAM and a non-zero base.
module tb_data_mem_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [31:0] a1, wd1, rd1, a3, wd3, rd3;
    logic        re1, we1, rv1, af1, re3, we3, rv3, af3;
    logic [1:0]  ws1, ws3;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset), .address(a1), .read_enable(re1), .read_valid(rv1),
        .read_data(rd1), .write_enable(we1), .write_data(wd1), .write_wstrb(ws1),
        .access_fault(af1)
    );

    data_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0100), .READ_LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset), .address(a3), .read_enable(re3), .read_valid(rv3),
        .read_data(rd3), .write_enable(we3), .write_data(wd3), .write_wstrb(ws3),
        .access_fault(af3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_store(input int sel, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s, output logic f);
        if (sel == 1) begin a1 = a; wd1 = d; ws1 = s; we1 = 1'b1; end
        else          begin a3 = a; wd3 = d; ws3 = s; we3 = 1'b1; end
        @(posedge clock); #1;
        we1 = 1'b0;
        we3 = 1'b0;
        f = (sel == 1) ? af1 : af3;
        $display("store dut%0d addr=%h data=%h wstrb=%b fault=%b", sel, a, d, s, f);
    endtask

    // Holds read_enable until read_valid, then spends the VALID->IDLE cycle
    // confirming the pulse is one cycle wide.
    task automatic do_load(input int sel, input string tag, input logic [31:0] a,
                           output logic [31:0] d, output logic f, output int lat);
        bit got = 0;
        d = 32'h0; f = 1'b0; lat = 0;
        if (sel == 1) begin a1 = a; re1 = 1'b1; end
        else          begin a3 = a; re3 = 1'b1; end
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clock); #1;
            if ((sel == 1) ? rv1 : rv3) begin
                got = 1;
                lat = i;
                d   = (sel == 1) ? rd1 : rd3;
                f   = (sel == 1) ? af1 : af3;
            end
        end
        re1 = 1'b0;
        re3 = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_timeout: observed no read_valid expected read_valid within 20 cycles", tag);
        end
        $display("load  dut%0d addr=%h data=%h fault=%b latency=%0d", sel, a, d, f, lat);
        @(posedge clock); #1;
        check({tag, "_pulse"}, {31'b0, (sel == 1) ? rv1 : rv3}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        f;
        int          lat;
        int          first, second, third;

        reset = 1'b0;
        a1 = 0; wd1 = 0; ws1 = 0; re1 = 0; we1 = 0;
        a3 = 0; wd3 = 0; ws3 = 0; re3 = 0; we3 = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_rv1", {31'b0, rv1}, 32'd0);
        check("rst_rd1", rd1, 32'h0);
        check("rst_af1", {31'b0, af1}, 32'd0);
        check("rst_rv3", {31'b0, rv3}, 32'd0);
        check("rst_rd3", rd3, 32'h0);
        check("rst_af3", {31'b0, af3}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Word store then latency-1 load
        do_store(1, 32'h10, 32'hDEADBEEF, 2'b10, f);
        check("st_word_fault", {31'b0, f}, 32'd0);
        do_load(1, "ld_word", 32'h10, d, f, lat);
        check("ld_word_lat", lat, 32'd1);
        check("ld_word_data", d, 32'hDEADBEEF);
        check("ld_word_fault", {31'b0, f}, 32'd0);
        check("rd_hold", rd1, 32'hDEADBEEF);

        // Byte merge and shifted read
        do_store(1, 32'h10, 32'h11223344, 2'b10, f);
        do_store(1, 32'h13, 32'hFFFFFF5A, 2'b00, f);
        check("st_byte_fault", {31'b0, f}, 32'd0);
        do_load(1, "ld_merge", 32'h10, d, f, lat);
        check("ld_merge_data", d, 32'h5A223344);
        do_load(1, "ld_shift3", 32'h13, d, f, lat);
        check("ld_shift3_data", d, 32'h0000005A);

        // Misaligned half and reserved width
        do_store(1, 32'h20, 32'hCAFEF00D, 2'b10, f);
        do_store(1, 32'h21, 32'h00001234, 2'b01, f);
        check("st_half_mis_fault", {31'b0, f}, 32'd1);
        @(posedge clock); #1;
        check("st_fault_pulse", {31'b0, af1}, 32'd0);
        do_load(1, "ld_after_mis", 32'h20, d, f, lat);
        check("ld_after_mis_data", d, 32'hCAFEF00D);
        check("ld_after_mis_fault", {31'b0, f}, 32'd0);
        do_store(1, 32'h24, 32'h0BADC0DE, 2'b10, f);
        do_store(1, 32'h24, 32'hFFFFFFFF, 2'b11, f);
        check("st_resv_fault", {31'b0, f}, 32'd1);
        do_load(1, "ld_after_resv", 32'h24, d, f, lat);
        check("ld_after_resv_data", d, 32'h0BADC0DE);
        do_store(1, 32'h26, 32'h0, 2'b10, f);
        check("st_word_mis_fault", {31'b0, f}, 32'd1);

        // Aligned upper half store
        do_store(1, 32'h22, 32'hFFFFABCD, 2'b01, f);
        check("st_half_fault", {31'b0, f}, 32'd0);
        do_load(1, "ld_half_w", 32'h20, d, f, lat);
        check("ld_half_w_data", d, 32'hABCDF00D);
        do_load(1, "ld_half_s", 32'h22, d, f, lat);
        check("ld_half_s_data", d, 32'h0000ABCD);

        // Range boundary on latency-1 instance (span 0x1000)
        do_store(1, 32'hFFC, 32'h00000077, 2'b10, f);
        check("st_last_fault", {31'b0, f}, 32'd0);
        do_load(1, "ld_last", 32'hFFC, d, f, lat);
        check("ld_last_data", d, 32'h00000077);
        check("ld_last_fault", {31'b0, f}, 32'd0);
        do_load(1, "ld_oor", 32'h1000, d, f, lat);
        check("ld_oor_lat", lat, 32'd1);
        check("ld_oor_data", d, 32'h0);
        check("ld_oor_fault", {31'b0, f}, 32'd1);
        do_store(1, 32'h1000, 32'h1, 2'b10, f);
        check("st_oor_fault", {31'b0, f}, 32'd1);

        // Latency-3 instance, base 0x100, span 0x100
        do_store(3, 32'h104, 32'h12345678, 2'b10, f);
        check("st3_fault", {31'b0, f}, 32'd0);
        do_load(3, "ld3", 32'h104, d, f, lat);
        check("ld3_lat", lat, 32'd3);
        check("ld3_data", d, 32'h12345678);
        check("ld3_fault", {31'b0, f}, 32'd0);

        // Address change during WAIT is ignored
        a3 = 32'h105; re3 = 1'b1;
        @(posedge clock); #1;
        a3 = 32'h200;
        lat = 0;
        for (int i = 2; i <= 20 && lat == 0; i++) begin
            @(posedge clock); #1;
            if (rv3) begin lat = i; d = rd3; f = af3; end
        end
        re3 = 1'b0;
        $display("load  dut3 addr=105 (changed to 200 in WAIT) data=%h fault=%b latency=%0d", d, f, lat);
        check("ld3_latch_lat", lat, 32'd3);
        check("ld3_latch_data", d, 32'h00123456);
        check("ld3_latch_fault", {31'b0, f}, 32'd0);
        @(posedge clock); #1;

        // Back-to-back loads with read_enable held high
        first = 0; second = 0; third = 0;
        a3 = 32'h104; re3 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clock); #1;
            if (rv3) begin
                if (first == 0)       first = i;
                else if (second == 0) second = i;
                else if (third == 0)  third = i;
            end
            if (i == 10) re3 = 1'b0;
        end
        re3 = 1'b0;
        $display("load  dut3 back-to-back valid cycles %0d %0d %0d", first, second, third);
        check("b2b_first", first, 32'd3);
        check("b2b_second", second, 32'd7);
        check("b2b_third", third, 32'd11);

        // Range on non-zero base
        do_load(3, "ld3_oor_hi", 32'h200, d, f, lat);
        check("ld3_oor_hi_data", d, 32'h0);
        check("ld3_oor_hi_fault", {31'b0, f}, 32'd1);
        do_load(3, "ld3_oor_lo", 32'hFC, d, f, lat);
        check("ld3_oor_lo_fault", {31'b0, f}, 32'd1);
        do_store(3, 32'hFC, 32'h1, 2'b10, f);
        check("st3_oor_lo_fault", {31'b0, f}, 32'd1);
        do_store(3, 32'h1FC, 32'hA5A5A5A5, 2'b10, f);
        check("st3_last_fault", {31'b0, f}, 32'd0);
        do_load(3, "ld3_last", 32'h1FC, d, f, lat);
        check("ld3_last_data", d, 32'hA5A5A5A5);
        check("ld3_last_fault", {31'b0, f}, 32'd0);

        // Reset during WAIT aborts the load; store under reset is dropped
        a3 = 32'h104; re3 = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; re3 = 1'b0;
        a1 = 32'h10; wd1 = 32'h0; ws1 = 2'b10; we1 = 1'b1;
        @(posedge clock); #1;
        we1 = 1'b0;
        check("rst_wait_rv3", {31'b0, rv3}, 32'd0);
        check("rst_wait_rd3", rd3, 32'h0);
        check("rst_wait_af3", {31'b0, af3}, 32'd0);
        check("rst_wait_rd1", rd1, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("rst_no_valid", {31'b0, rv3}, 32'd0);
        end
        do_load(3, "ld3_post_rst", 32'h104, d, f, lat);
        check("ld3_post_rst_lat", lat, 32'd3);
        check("ld3_post_rst_data", d, 32'h12345678);
        do_load(1, "ld1_post_rst", 32'h10, d, f, lat);
        check("ld1_post_rst_data", d, 32'h5A223344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
